ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline; consumes the IDEX register outputs directly.
//  Contains RS/RT forwarding muxes, ALU, branch target/decision and an iterative
//  32-cycle multiply/divide unit with HI/LO registers.
//  Raises stall while mult/div is busy so IF/ID/IDEX hold and EX/MEM receives a bubble.
// PARAMETERS
//  WIDTH     32  datapath width; only 32 is supported
//  MD_CYCLES 32  iteration count of the mult/div unit; must equal WIDTH
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous active-high reset
//  ex_RegDst      in   1   1: dest=rd, 0: dest=rt
//  ex_AluSrc      in   1   1: B operand=immediate, 0: forwarded rt value
//  ex_AluOp       in   2   00 add, 01 sub, 10 R-type (funct), 11 or
//  ex_branch      in   1   beq in EX
//  pc4            in   32  PC+4 of the instruction in EX
//  read_data1/2   in   32  register-file values of rs/rt
//  immediate      in   32  sign-extended imm; [5:0]=funct, [10:6]=shamt
//  rs, rt, rd     in   5   register numbers
//  exmem_RegWrite in   1   EX/MEM stage writes a register
//  exmem_rd       in   5   EX/MEM destination register
//  exmem_result   in   32  EX/MEM ALU result
//  memwb_RegWrite in   1   MEM/WB stage writes a register
//  memwb_rd       in   5   MEM/WB destination register
//  memwb_result   in   32  MEM/WB write-back value
//  alu_result     out  32  ALU/mfhi/mflo result
//  store_data     out  32  forwarded rt value, for sw
//  dest_reg       out  5   rd or rt per ex_RegDst
//  zero           out  1   alu_result == 0
//  branch_taken   out  1   ex_branch & zero
//  branch_target  out  32  pc4 + (immediate << 2), mod 2^32
//  stall          out  1   hold IF/ID/IDEX; insert bubble into EX/MEM
// BEHAVIOUR
//  Forwarding, per operand (rs->A, rt->B): exmem wins if exmem_RegWrite & exmem_rd!=0 & match;
//   else memwb under the same rule; else read_data. $0 is never forwarded.
//  ALU funct under AluOp=10: 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor,
//   2A slt (signed), 2B sltu, 00 sll B by shamt, 02 srl B by shamt, 10 mfhi, 12 mflo;
//   other funct gives 0. Arithmetic wraps mod 2^32; no overflow traps.
//  All outputs except stall are combinational (0-cycle latency), including during reset.
//  Mult/div funct: 18 mult, 19 multu, 1A div, 1B divu.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: a mult/div op present with rst=0 -> stall=1 combinationally.
//    The unit latches operand magnitudes and sign flags; cnt=0; next state BUSY.
//   BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; stall=1;
//    after MD_CYCLES steps, next state DONE.
//   DONE: stall=0; sign fix-up applied; HI/LO written at this edge; next state IDLE.
//   Each mult/div occupies EX for 34 cycles; stall is high for 33 of them.
//  Results:
//   mult/multu: {HI,LO} = 64-bit product.
//   div/divu: LO=quotient, HI=remainder; remainder takes the dividend's sign.
//   Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
//   div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  mfhi/mflo right after DONE read the new HI/LO; no extra stall.
//  Operands are captured in IDLE, so forwarding-source changes during BUSY have no effect.
//  Reset: state=IDLE, cnt=0, HI=LO=0, stall=0; a mult/div in flight is aborted, HI/LO untouched by it.
// CONFIGURATION
//  MULDIV_EN defined: mult/div unit, HI/LO and the FSM are present as described.
//  MULDIV_EN undefined: funct 18-1B give alu_result=0 and no side effect;
//   mfhi/mflo return 0; stall is tied to 0; no FSM or HI/LO flops are built.
// TESTING
//  1 add rs=1(5), rt=2(7), exmem_rd=1 with value 9, RegWrite=1 -> alu_result=16.
//    Same case with exmem_rd=0 -> alu_result=12.
//  2 Forwarding priority: exmem and memwb both target rs -> exmem value used.
//    exmem_RegWrite=0 -> memwb value used.
//  3 beq, A=B=3, pc4=0x100, imm=-2 -> zero=1, branch_taken=1, branch_target=0x0F8.
//  4 mult 0xFFFFFFFF x 2 -> stall high 33 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE.
//    multu on the same operands -> HI=1, LO=0xFFFFFFFE.
//  5 div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 5/0 -> LO=0xFFFFFFFF, HI=5.
//  6 rst pulsed at BUSY cycle 10 -> stall=0 next cycle, HI=LO=0.
//    A new mult afterwards completes normally.
//    Build without MULDIV_EN: a mult op never raises stall.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX bundle for ex_stage: pipeline-register inputs, forwarding sources and EX results.
// The master side drives the pipeline inputs; the slave side (ex_stage) returns the results.
interface ex_stage_if #(
    parameter int WIDTH = 32
);
    logic             ex_RegDst;
    logic             ex_AluSrc;
    logic [1:0]       ex_AluOp;
    logic             ex_branch;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] read_data1;
    logic [WIDTH-1:0] read_data2;
    logic [WIDTH-1:0] immediate;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic             exmem_RegWrite;
    logic [4:0]       exmem_rd;
    logic [WIDTH-1:0] exmem_result;
    logic             memwb_RegWrite;
    logic [4:0]       memwb_rd;
    logic [WIDTH-1:0] memwb_result;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] store_data;
    logic [4:0]       dest_reg;
    logic             zero;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             stall;

    modport master (
        output ex_RegDst, ex_AluSrc, ex_AluOp, ex_branch, pc4, read_data1, read_data2,
               immediate, rs, rt, rd, exmem_RegWrite, exmem_rd, exmem_result,
               memwb_RegWrite, memwb_rd, memwb_result,
        input  alu_result, store_data, dest_reg, zero, branch_taken, branch_target, stall
    );

    modport slave (
        input  ex_RegDst, ex_AluSrc, ex_AluOp, ex_branch, pc4, read_data1, read_data2,
               immediate, rs, rt, rd, exmem_RegWrite, exmem_rd, exmem_result,
               memwb_RegWrite, memwb_rd, memwb_result,
        output alu_result, store_data, dest_reg, zero, branch_taken, branch_target, stall
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch resolution and an optional
// iterative mult/div unit with HI/LO (built only when MULDIV_EN is defined).
module ex_stage #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_stage_if.slave bus
);
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] fwd_b_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;
    logic [5:0]       funct_s;
    logic [4:0]       shamt_s;

    assign funct_s = bus.immediate[5:0];
    assign shamt_s = bus.immediate[10:6];

    // A operand forwarding: the younger EX/MEM result beats MEM/WB; $0 is never forwarded
    always_comb begin
        op_a_s = bus.read_data1;
        if (bus.exmem_RegWrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == bus.rs)) begin
            op_a_s = bus.exmem_result;
        end else if (bus.memwb_RegWrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.rs)) begin
            op_a_s = bus.memwb_result;
        end else begin
            op_a_s = bus.read_data1;
        end
    end

    // B operand forwarding, same priority as A
    always_comb begin
        fwd_b_s = bus.read_data2;
        if (bus.exmem_RegWrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == bus.rt)) begin
            fwd_b_s = bus.exmem_result;
        end else if (bus.memwb_RegWrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.rt)) begin
            fwd_b_s = bus.memwb_result;
        end else begin
            fwd_b_s = bus.read_data2;
        end
    end

    assign op_b_s = bus.ex_AluSrc ? bus.immediate : fwd_b_s;

    // ALU; mult/div functs fall into the default arm and produce 0
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (bus.ex_AluOp)
            2'b00: alu_s = op_a_s + op_b_s;
            2'b01: alu_s = op_a_s - op_b_s;
            2'b11: alu_s = op_a_s | op_b_s;
            2'b10: begin
                case (funct_s)
                    6'h20, 6'h21: alu_s = op_a_s + op_b_s;
                    6'h22, 6'h23: alu_s = op_a_s - op_b_s;
                    6'h24:        alu_s = op_a_s & op_b_s;
                    6'h25:        alu_s = op_a_s | op_b_s;
                    6'h26:        alu_s = op_a_s ^ op_b_s;
                    6'h27:        alu_s = ~(op_a_s | op_b_s);
                    6'h2A:        alu_s = {{(WIDTH-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
                    6'h2B:        alu_s = {{(WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
                    6'h00:        alu_s = op_b_s << shamt_s;
                    6'h02:        alu_s = op_b_s >> shamt_s;
                    6'h10:        alu_s = hi_s;
                    6'h12:        alu_s = lo_s;
                    default:      alu_s = {WIDTH{1'b0}};
                endcase
            end
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    assign bus.alu_result    = alu_s;
    assign bus.store_data    = fwd_b_s;
    assign bus.dest_reg      = bus.ex_RegDst ? bus.rd : bus.rt;
    assign bus.zero          = (alu_s == {WIDTH{1'b0}});
    assign bus.branch_taken  = bus.ex_branch & bus.zero;
    assign bus.branch_target = bus.pc4 + {bus.immediate[WIDTH-3:0], 2'b00};

`ifdef MULDIV_EN
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [4:0] CNT_LAST = 5'(MD_CYCLES - 1);

    md_state_t          state_r;
    md_state_t          state_nx_s;
    logic               stall_s;
    logic [4:0]         cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opd_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               md_op_s;
    logic               signed_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign md_op_s  = (bus.ex_AluOp == 2'b10) && (funct_s[5:2] == 4'b0110);
    assign signed_s = ~funct_s[0];
    assign mag_a_s  = (signed_s && op_a_s[WIDTH-1])  ? -op_a_s  : op_a_s;
    assign mag_b_s  = (signed_s && fwd_b_s[WIDTH-1]) ? -fwd_b_s : fwd_b_s;

    // Next state and stall
    always_comb begin
        state_nx_s = state_r;
        stall_s    = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (md_op_s) begin
                    state_nx_s = MD_BUSY;
                    stall_s    = 1'b1;
                end else begin
                    state_nx_s = MD_IDLE;
                    stall_s    = 1'b0;
                end
            end
            MD_BUSY: begin
                stall_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = MD_DONE;
                end else begin
                    state_nx_s = MD_BUSY;
                end
            end
            MD_DONE: state_nx_s = MD_IDLE;
            default: state_nx_s = MD_IDLE;
        endcase
    end

    assign bus.stall = stall_s & ~rst;

    // One iteration: acc holds {HI-part, LO-part}; shift-add for mult, restoring subtract for div
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opd_r};
        if (is_div_r) begin
            if (div_trial_s[WIDTH]) begin
                step_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end else begin
                step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign fix-up; a zero divisor leaves the all-ones quotient and the dividend in the remainder
    always_comb begin
        prod_s = neg_q_r ? -acc_r : acc_r;
        if (neg_q_r && (opd_r != {WIDTH{1'b0}})) begin
            quo_s = -acc_r[WIDTH-1:0];
        end else begin
            quo_s = acc_r[WIDTH-1:0];
        end
        rem_s = neg_r_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    end

    // Mult/div state, datapath and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= MD_IDLE;
            cnt_r    <= 5'd0;
            acc_r    <= {(2*WIDTH){1'b0}};
            opd_r    <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                MD_IDLE: begin
                    if (md_op_s) begin
                        acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
                        opd_r    <= mag_b_s;
                        is_div_r <= funct_s[1];
                        neg_q_r  <= signed_s & (op_a_s[WIDTH-1] ^ fwd_b_s[WIDTH-1]);
                        neg_r_r  <= signed_s & op_a_s[WIDTH-1];
                        cnt_r    <= 5'd0;
                    end
                end
                MD_BUSY: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                MD_DONE: begin
                    if (is_div_r) begin
                        hi_r <= rem_s;
                        lo_r <= quo_s;
                    end else begin
                        hi_r <= prod_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_s[WIDTH-1:0];
                    end
                end
                default: state_r <= MD_IDLE;
            endcase
        end
    end

    assign hi_s = hi_r;
    assign lo_s = lo_r;
`else
    logic unused_s;

    assign unused_s  = ^{clk, rst};
    assign hi_s      = {WIDTH{1'b0}};
    assign lo_s      = {WIDTH{1'b0}};
    assign bus.stall = 1'b0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of combinational vectors through a scoreboard queue, plus
// mult/div, HI/LO and mid-operation reset sequences (expectations depend on MULDIV_EN).
module tb_ex_stage;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULDIV_EN
    localparam int   EXP_STALL = 33;
    localparam logic EXP_ON    = 1'b1;
`else
    localparam int   EXP_STALL = 0;
    localparam logic EXP_ON    = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        regdst;
        logic        branch;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        exwr;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mwwr;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
        logic [31:0] exp_res;
        logic [31:0] exp_store;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] store;
        logic [31:0] tgt;
        logic [4:0]  dest;
        logic        z;
        logic        bt;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    md_t  md_q[$];

    function automatic vec_t mk(input string n, input logic [1:0] op, input logic src,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] er, input logic [31:0] es);
        vec_t v;
        v.name = n;  v.aluop = op;  v.alusrc = src;  v.regdst = (op == 2'b10);
        v.branch = 1'b0;  v.pc4 = 32'h0000_0100;  v.rd1 = a;  v.rd2 = b;  v.imm = imm;
        v.rs = 5'd1;  v.rt = 5'd2;  v.rd = 5'd3;
        v.exwr = 1'b0;  v.exrd = 5'd0;  v.exres = 32'd0;
        v.mwwr = 1'b0;  v.mwrd = 5'd0;  v.mwres = 32'd0;
        v.exp_res = er;  v.exp_store = es;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.ex_AluOp = v.aluop;  bus.ex_AluSrc = v.alusrc;  bus.ex_RegDst = v.regdst;
        bus.ex_branch = v.branch;  bus.pc4 = v.pc4;  bus.read_data1 = v.rd1;
        bus.read_data2 = v.rd2;  bus.immediate = v.imm;  bus.rs = v.rs;  bus.rt = v.rt;
        bus.rd = v.rd;  bus.exmem_RegWrite = v.exwr;  bus.exmem_rd = v.exrd;
        bus.exmem_result = v.exres;  bus.memwb_RegWrite = v.mwwr;  bus.memwb_rd = v.mwrd;
        bus.memwb_result = v.mwres;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Drive one vector, record its expectations, compare on the falling edge
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        apply(v);
        e.name  = v.name;
        e.res   = v.exp_res;
        e.store = v.exp_store;
        e.tgt   = v.pc4 + (v.imm << 2);
        e.dest  = v.regdst ? v.rd : v.rt;
        e.z     = (v.exp_res == 32'd0);
        e.bt    = v.branch & (v.exp_res == 32'd0);
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk({g.name, "/res"},   bus.alu_result, g.res);
        chk({g.name, "/store"}, bus.store_data, g.store);
        chk({g.name, "/dest"},  {27'd0, bus.dest_reg}, {27'd0, g.dest});
        chk({g.name, "/flags"}, {30'd0, bus.zero, bus.branch_taken}, {30'd0, g.z, g.bt});
        chk({g.name, "/tgt"},   bus.branch_target, g.tgt);
        chk({g.name, "/stall"}, {31'd0, bus.stall}, 32'd0);
    endtask

    task automatic read_hilo(input string n, input logic [5:0] f, input logic [31:0] exp);
        @(posedge clk);
        #1;
        apply(mk(n, 2'b10, 1'b0, 32'd0, 32'd0, {26'd0, f}, 32'd0, 32'd0));
        @(negedge clk);
        chk({n, "/val"},   bus.alu_result, exp);
        chk({n, "/stall"}, {31'd0, bus.stall}, 32'd0);
    endtask

    // Issue a mult/div, count stall cycles (operands disturbed while busy), then read HI/LO
    task automatic run_md(input string n, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e);
        md_t m;
        int  cnt;
        m.name = n;
`ifdef MULDIV_EN
        m.hi = hi_e;
        m.lo = lo_e;
`else
        m.hi = 32'd0;
        m.lo = 32'd0;
`endif
        @(posedge clk);
        #1;
        apply(mk(n, 2'b10, 1'b0, a, b, {26'd0, f}, 32'd0, b));
        md_q.push_back(m);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) chk({n, "/op_res"}, bus.alu_result, 32'd0);
            if (i == 1) begin
                bus.read_data1 = ~a;
                bus.read_data2 = a ^ 32'h5A5A_5A5A;
            end
            if (bus.stall) cnt = cnt + 1;
            else break;
        end
        chk({n, "/stall_cycles"}, 32'(cnt), 32'(EXP_STALL));
        m = md_q.pop_front();
        read_hilo({m.name, "_hi"}, 6'h10, m.hi);
        read_hilo({m.name, "_lo"}, 6'h12, m.lo);
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        apply(mk("rst_add", 2'b00, 1'b0, 32'd2, 32'd3, 32'd0, 32'd5, 32'd3));
        @(negedge clk);
        chk("rst_add/res",   bus.alu_result, 32'd5);
        chk("rst_add/stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        v = mk("fwd_ex", 2'b00, 1'b0, 32'd5, 32'd7, 32'd0, 32'd16, 32'd7);
        v.exwr = 1'b1; v.exrd = 5'd1; v.exres = 32'd9; vecs.push_back(v);
        v = mk("ex_rd0", 2'b00, 1'b0, 32'd5, 32'd7, 32'd0, 32'd12, 32'd7);
        v.exwr = 1'b1; v.exrd = 5'd0; v.exres = 32'd9; vecs.push_back(v);
        v = mk("fwd_r0", 2'b00, 1'b0, 32'd5, 32'd7, 32'd0, 32'd12, 32'd7);
        v.rs = 5'd0; v.exwr = 1'b1; v.exrd = 5'd0; v.exres = 32'd9;
        v.mwwr = 1'b1; v.mwrd = 5'd0; v.mwres = 32'd20; vecs.push_back(v);
        v = mk("no_match", 2'b00, 1'b0, 32'd5, 32'd7, 32'd0, 32'd12, 32'd7);
        v.exwr = 1'b1; v.exrd = 5'd3; v.exres = 32'd99; vecs.push_back(v);
        v = mk("prio", 2'b00, 1'b0, 32'd5, 32'd7, 32'd0, 32'd16, 32'd7);
        v.exwr = 1'b1; v.exrd = 5'd1; v.exres = 32'd9;
        v.mwwr = 1'b1; v.mwrd = 5'd1; v.mwres = 32'd20; vecs.push_back(v);
        v = mk("fwd_mw", 2'b00, 1'b0, 32'd5, 32'd7, 32'd0, 32'd27, 32'd7);
        v.exwr = 1'b0; v.exrd = 5'd1; v.exres = 32'd9;
        v.mwwr = 1'b1; v.mwrd = 5'd1; v.mwres = 32'd20; vecs.push_back(v);
        v = mk("fwd_b_mw", 2'b01, 1'b0, 32'd50, 32'd7, 32'd0, 32'd10, 32'd40);
        v.mwwr = 1'b1; v.mwrd = 5'd2; v.mwres = 32'd40; vecs.push_back(v);
        v = mk("fwd_b_ex", 2'b01, 1'b0, 32'd50, 32'd7, 32'd0, 32'd42, 32'd8);
        v.exwr = 1'b1; v.exrd = 5'd2; v.exres = 32'd8;
        v.mwwr = 1'b1; v.mwrd = 5'd2; v.mwres = 32'd40; vecs.push_back(v);
        vecs.push_back(mk("imm_add", 2'b00, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd3, 32'd7));
        vecs.push_back(mk("ori", 2'b11, 1'b1, 32'h0000_00F0, 32'd7, 32'h0000_000F, 32'h0000_00FF, 32'd7));
        v = mk("beq_t", 2'b01, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFFE, 32'd0, 32'd3);
        v.branch = 1'b1; vecs.push_back(v);
        v = mk("beq_nt", 2'b01, 1'b0, 32'd3, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd4);
        v.branch = 1'b1; vecs.push_back(v);
        vecs.push_back(mk("add", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h20, 32'h8000_0100, 32'h0000_00FF));
        vecs.push_back(mk("sub", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h22, 32'h7FFF_FF02, 32'h0000_00FF));
        vecs.push_back(mk("and", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h24, 32'h0000_0001, 32'h0000_00FF));
        vecs.push_back(mk("or", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h25, 32'h8000_00FF, 32'h0000_00FF));
        vecs.push_back(mk("xor", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h26, 32'h8000_00FE, 32'h0000_00FF));
        vecs.push_back(mk("nor", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h27, 32'h7FFF_FF00, 32'h0000_00FF));
        vecs.push_back(mk("slt_neg", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h2A, 32'd1, 32'h0000_00FF));
        vecs.push_back(mk("sltu_big", 2'b10, 1'b0, 32'h8000_0001, 32'h0000_00FF, 32'h2B, 32'd0, 32'h0000_00FF));
        vecs.push_back(mk("slt_pos", 2'b10, 1'b0, 32'd5, 32'hFFFF_FFFF, 32'h2A, 32'd0, 32'hFFFF_FFFF));
        vecs.push_back(mk("sltu_small", 2'b10, 1'b0, 32'd5, 32'hFFFF_FFFF, 32'h2B, 32'd1, 32'hFFFF_FFFF));
        vecs.push_back(mk("sll4", 2'b10, 1'b0, 32'd0, 32'h0000_00FF, 32'h100, 32'h0000_0FF0, 32'h0000_00FF));
        vecs.push_back(mk("srl4", 2'b10, 1'b0, 32'd0, 32'h0000_00FF, 32'h102, 32'h0000_000F, 32'h0000_00FF));
        vecs.push_back(mk("sll31", 2'b10, 1'b0, 32'd0, 32'd1, 32'h7C0, 32'h8000_0000, 32'd1));
        vecs.push_back(mk("addu_wrap", 2'b10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h21, 32'd0, 32'd1));
        vecs.push_back(mk("subu_wrap", 2'b10, 1'b0, 32'd5, 32'd7, 32'h23, 32'hFFFF_FFFE, 32'd7));
        vecs.push_back(mk("bad_funct", 2'b10, 1'b0, 32'd5, 32'd7, 32'h3F, 32'd0, 32'd7));
        vecs.push_back(mk("mfhi_rst", 2'b10, 1'b0, 32'd5, 32'd7, 32'h10, 32'd0, 32'd7));
        vecs.push_back(mk("mflo_rst", 2'b10, 1'b0, 32'd5, 32'd7, 32'h12, 32'd0, 32'd7));

        foreach (vecs[i]) run_vec(vecs[i]);

        run_md("mult_m1x2", 6'h18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu_m1x2", 6'h19, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_md("mult_min2", 6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_md("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_7_m2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("divu_5_0", 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_md("div_m5_0", 6'h1A, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_md("div_min_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Abort a mult with reset in the middle of BUSY; HI/LO must come back cleared
        @(posedge clk);
        #1;
        apply(mk("abort", 2'b10, 1'b0, 32'd3, 32'd5, 32'h18, 32'd0, 32'd5));
        for (int i = 0; i < 11; i++) @(negedge clk);
        chk("abort/busy_stall", {31'd0, bus.stall}, {31'd0, EXP_ON});
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(mk("abort_nop", 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        @(negedge clk);
        chk("abort/rst_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort/post_stall", {31'd0, bus.stall}, 32'd0);
        read_hilo("abort_hi", 6'h10, 32'd0);
        read_hilo("abort_lo", 6'h12, 32'd0);
        run_md("mult_after_rst", 6'h18, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
